// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath side uses the master modport, and the controller uses the slave modport.
interface pipe_hazard_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] e_dst;
  logic [4:0] m_dst;
  logic [1:0] e_tnew;
  logic [1:0] m_tnew;
  logic       d_md_use;
  logic       e_md_start;
  logic       e_md_div;
  logic       d_eret;
  logic       e_mtc0_epc;
  logic       m_mtc0_epc;
  logic       m_exc;
  logic       stall;
  logic       fd_we;
  logic       req;
  logic       md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, e_dst, m_dst, e_tnew, m_tnew,
    output d_md_use, e_md_start, e_md_div, d_eret, e_mtc0_epc, m_mtc0_epc, m_exc,
    input  stall, fd_we, req, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, e_dst, m_dst, e_tnew, m_tnew,
    input  d_md_use, e_md_start, e_md_div, d_eret, e_mtc0_epc, m_mtc0_epc, m_exc,
    output stall, fd_we, req, md_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline, with an optional mult/div scheduler.
// Define PIPE_CTRL_MDU_EN to build the mult/div scheduler. By default it is removed.
module pipe_hazard_ctrl (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  logic stall_rs, stall_rt, stall_md, stall_eret;

  // $0 never creates a dependence, whatever the E/M destination fields hold
  assign stall_rs = (hz.d_rs != 5'd0) &&
                    (((hz.d_rs == hz.e_dst) && (hz.e_tnew > hz.d_tuse_rs)) ||
                     ((hz.d_rs == hz.m_dst) && (hz.m_tnew > hz.d_tuse_rs)));
  assign stall_rt = (hz.d_rt != 5'd0) &&
                    (((hz.d_rt == hz.e_dst) && (hz.e_tnew > hz.d_tuse_rt)) ||
                     ((hz.d_rt == hz.m_dst) && (hz.m_tnew > hz.d_tuse_rt)));
  assign stall_eret = hz.d_eret && (hz.e_mtc0_epc || hz.m_mtc0_epc);

  assign hz.req   = hz.m_exc;
  assign hz.stall = (stall_rs || stall_rt || stall_md || stall_eret) && !hz.req;
  assign hz.fd_we = !hz.stall;

`ifdef PIPE_CTRL_MDU_EN
  typedef enum logic {StIdle, StBusy} md_state_e;

  md_state_e  state_q;
  logic [3:0] cnt_q;

  // A start that coincides with an exception is squashed. A running op always completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hz.e_md_start && !hz.req) begin
            state_q <= StBusy;
            cnt_q   <= hz.e_md_div ? 4'd10 : 4'd5;
          end
        end
        StBusy: begin
          if (cnt_q == 4'd1) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign hz.md_busy = (state_q == StBusy);
  assign stall_md   = hz.d_md_use && (hz.e_md_start || hz.md_busy);
`else
  logic unused_md;
  assign unused_md  = ^{hz.d_md_use, hz.e_md_start, hz.e_md_div, clk, reset};
  assign hz.md_busy = 1'b0;
  assign stall_md   = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl.
// A driver pushes the expected outputs into a queue, and a monitor on the falling edge checks them.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_CTRL_MDU_EN
  localparam bit MduEn = 1'b1;
`else
  localparam bit MduEn = 1'b0;
`endif

  typedef struct {
    logic       reset;
    logic [4:0] d_rs, d_rt, e_dst, m_dst;
    logic [1:0] tuse_rs, tuse_rt, e_tnew, m_tnew;
    logic       d_md_use, e_md_start, e_md_div, d_eret, e_mtc0, m_mtc0, m_exc;
  } stim_t;

  typedef struct {
    logic stall, fd_we, req, busy;
  } exp_t;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  exp_q[$];
  stim_t cur;
  int    md_rem = 0;  // remaining busy cycles of the mult/div unit (reference model)

  task automatic check(input string name, input logic act, input logic req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0b, expected %0b", name, $time, act, req_v);
    end
  endtask

  function automatic stim_t zero_stim();
    stim_t s;
    s.reset = 1'b0; s.d_rs = '0; s.d_rt = '0; s.e_dst = '0; s.m_dst = '0;
    s.tuse_rs = 2'd3; s.tuse_rt = 2'd3; s.e_tnew = '0; s.m_tnew = '0;
    s.d_md_use = 1'b0; s.e_md_start = 1'b0; s.e_md_div = 1'b0; s.d_eret = 1'b0;
    s.e_mtc0 = 1'b0; s.m_mtc0 = 1'b0; s.m_exc = 1'b0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.reset      = ($urandom_range(0, 39) == 0);
    s.d_rs       = 5'($urandom_range(0, 3));
    s.d_rt       = 5'($urandom_range(0, 3));
    s.e_dst      = 5'($urandom_range(0, 3));
    s.m_dst      = 5'($urandom_range(0, 3));
    s.tuse_rs    = 2'($urandom_range(0, 3));
    s.tuse_rt    = 2'($urandom_range(0, 3));
    s.e_tnew     = 2'($urandom_range(0, 3));
    s.m_tnew     = 2'($urandom_range(0, 3));
    s.d_md_use   = ($urandom_range(0, 2) == 0);
    s.e_md_start = ($urandom_range(0, 5) == 0);
    s.e_md_div   = 1'($urandom_range(0, 1));
    s.d_eret     = ($urandom_range(0, 3) == 0);
    s.e_mtc0     = ($urandom_range(0, 3) == 0);
    s.m_mtc0     = ($urandom_range(0, 3) == 0);
    s.m_exc      = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  function automatic bit src_haz(input logic [4:0] r, input logic [1:0] tuse, input stim_t s);
    if (r == 0) return 1'b0;
    return (r == s.e_dst && int'(s.e_tnew) > int'(tuse)) ||
           (r == s.m_dst && int'(s.m_tnew) > int'(tuse));
  endfunction

  function automatic exp_t expect_of(input stim_t s, input int rem);
    exp_t e;
    bit   hazard;
    hazard = src_haz(s.d_rs, s.tuse_rs, s) || src_haz(s.d_rt, s.tuse_rt, s) ||
             (MduEn && s.d_md_use && (s.e_md_start || rem > 0)) ||
             (s.d_eret && (s.e_mtc0 || s.m_mtc0));
    e.req   = s.m_exc;
    e.stall = hazard && !s.m_exc;
    e.fd_we = !e.stall;
    e.busy  = (rem > 0);
    return e;
  endfunction

  // Advance the mult/div reference by one clock edge, using the inputs held before that edge.
  function automatic int next_rem(input stim_t s, input int rem);
    if (s.reset) return 0;
    if (rem > 0) return rem - 1;
    if (MduEn && s.e_md_start && !s.m_exc) return s.e_md_div ? 10 : 5;
    return 0;
  endfunction

  task automatic drive(input stim_t s);
    cur           = s;
    reset         = s.reset;
    hz.d_rs       = s.d_rs;
    hz.d_rt       = s.d_rt;
    hz.e_dst      = s.e_dst;
    hz.m_dst      = s.m_dst;
    hz.d_tuse_rs  = s.tuse_rs;
    hz.d_tuse_rt  = s.tuse_rt;
    hz.e_tnew     = s.e_tnew;
    hz.m_tnew     = s.m_tnew;
    hz.d_md_use   = s.d_md_use;
    hz.e_md_start = s.e_md_start;
    hz.e_md_div   = s.e_md_div;
    hz.d_eret     = s.d_eret;
    hz.e_mtc0_epc = s.e_mtc0;
    hz.m_mtc0_epc = s.m_mtc0;
    hz.m_exc      = s.m_exc;
  endtask

  task automatic apply(input stim_t s);
    @(posedge clk);
    md_rem = next_rem(cur, md_rem);
    #1;
    drive(s);
    exp_q.push_back(expect_of(s, md_rem));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall", hz.stall, e.stall);
      check("fd_we", hz.fd_we, e.fd_we);
      check("req", hz.req, e.req);
      check("md_busy", hz.md_busy, e.busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    s = zero_stim();
    s.reset = 1'b1;
    drive(s);
    apply(s);
    apply(s);
    apply(zero_stim());

    // RAW hazard on rs from E, then resolved by tnew
    s = zero_stim(); s.d_rs = 5'd3; s.tuse_rs = 2'd0; s.e_dst = 5'd3; s.e_tnew = 2'd2;
    apply(s);
    s.e_tnew = 2'd0;
    apply(s);
    // $0 never stalls
    s = zero_stim(); s.d_rs = 5'd0; s.e_dst = 5'd0; s.e_tnew = 2'd2; s.tuse_rs = 2'd0;
    apply(s);
    // rt hazard from M
    s = zero_stim(); s.d_rt = 5'd7; s.tuse_rt = 2'd0; s.m_dst = 5'd7; s.m_tnew = 2'd1;
    apply(s);
    // eret behind mtc0 EPC
    s = zero_stim(); s.d_eret = 1'b1; s.m_mtc0 = 1'b1;
    apply(s);
    s.m_mtc0 = 1'b0;
    apply(s);

    // Div with a dependent HI/LO user waiting in D
    s = zero_stim(); s.e_md_start = 1'b1; s.e_md_div = 1'b1; s.d_md_use = 1'b1;
    apply(s);
    s.e_md_start = 1'b0;
    repeat (12) apply(s);

    // Start cancelled by a simultaneous exception, which also masks a hazard stall
    s = zero_stim(); s.e_md_start = 1'b1; s.m_exc = 1'b1; s.d_md_use = 1'b1;
    s.d_rs = 5'd2; s.e_dst = 5'd2; s.e_tnew = 2'd3; s.tuse_rs = 2'd0;
    apply(s);
    apply(zero_stim());
    apply(zero_stim());

    // Mult interrupted by reset, then a fresh mult
    s = zero_stim(); s.e_md_start = 1'b1;
    apply(s);
    apply(zero_stim());
    apply(zero_stim());
    s = zero_stim(); s.reset = 1'b1; s.e_md_start = 1'b1;
    apply(s);
    apply(zero_stim());
    s = zero_stim(); s.e_md_start = 1'b1;
    apply(s);
    repeat (7) apply(zero_stim());

    repeat (500) apply(rand_stim());

    @(posedge clk);
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It decides each cycle whether the D stage must hold and a bubble be inserted into the D/E register (`stall`), and whether all pipeline registers must be flushed for exception entry (`req`). It also schedules the multi-cycle multiply/divide unit, which the D/E register cannot see. The block sits beside the datapath in the CPU top and drives the `stall`/`req`/`we` inputs of the F/D, D/E, E/M and M/W registers.

## Interface
- No parameters. `MULT_CYC`/`DIV_CYC` latencies are fixed at 5/10.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- d_rs, d_rt  in  5  D-stage source register numbers
- d_tuse_rs, d_tuse_rt  in  2  cycles until D instruction consumes rs/rt (3 = unused)
- e_dst, m_dst  in  5  destination register of E/M instruction (0 = none)
- e_tnew, m_tnew  in  2  cycles until E/M result is forwardable
- d_md_use  in  1  D instruction reads/writes HI/LO or starts mult/div
- e_md_start  in  1  E instruction starts mult/div this cycle
- e_md_div  in  1  qualifies e_md_start: 1 = div, 0 = mult
- d_eret  in  1  eret in D
- e_mtc0_epc, m_mtc0_epc  in  1  mtc0 to EPC ($14) in E/M
- m_exc  in  1  exception or interrupt taken at M (from CP0)
- stall  out  1  hold PC and F/D; bubble into D/E (pc/bd preserved there)
- fd_we  out  1  = ~stall
- req  out  1  flush F/D, D/E, E/M, M/W; D/E pc forced to 0x4180
- md_busy  out  1  mult/div unit computing

## Operation
- Data hazard (combinational): stall_rs = rs≠0 & ((rs==e_dst & e_tnew>d_tuse_rs) | (rs==m_dst & m_tnew>d_tuse_rs)); same for rt.
- MD hazard: stall_md = d_md_use & (e_md_start | md_busy).
- ERET hazard: stall_eret = d_eret & (e_mtc0_epc | m_mtc0_epc).
- stall = (stall_rs | stall_rt | stall_md | stall_eret) & ~req.
- req = m_exc (combinational, same-cycle). req overrides stall.
- MD scheduler FSM, states IDLE and BUSY, 4-bit counter `cnt`:
  - IDLE: on e_md_start & ~req → BUSY, cnt ← 5 (mult) or 10 (div).
  - BUSY: cnt ← cnt−1 each cycle; on cnt==1 → IDLE, cnt ← 0.
  - e_md_start while BUSY cannot occur (stall_md blocks it); if asserted, ignore.
  - req in any state: start in same cycle is cancelled; a running operation continues (it is architecturally committed).
- md_busy = (state==BUSY).

## Timing
- Reset: state IDLE, cnt 0, md_busy 0. stall and req follow inputs combinationally (0 when inputs are 0).
- Mult started in E at edge t: md_busy high cycles t+1..t+5, low at t+6; a dependent mfhi in D stalls cycles t..t+5 and enters E at edge t+6. Div: busy t+1..t+10.
- Reset asserted mid-operation: next edge forces IDLE/cnt 0 regardless of other inputs.
- Simultaneous m_exc and any hazard: req=1, stall=0.
- Zero-latency path: all outputs except md_busy are combinational from inputs; md_busy is registered.

## Configuration
- `PIPE_CTRL_MDU_EN` defined: MD scheduler FSM and stall_md present as above.
- Undefined: FSM and counter removed, md_busy tied 0, stall_md = 0 (for cores without mult/div).

## Test plan
- d_rs=3, d_tuse_rs=0, e_dst=3, e_tnew=2 -> stall=1, fd_we=0; with e_tnew=0 -> stall=0.
- d_rs=0, e_dst=0, e_tnew=2, d_tuse_rs=0 -> stall=0 ($0 never stalls).
- e_md_start=1, e_md_div=1 at edge 0, d_md_use=1 held -> md_busy 1 for exactly 10 cycles, stall=1 through cycle 10, 0 at cycle 11.
- e_md_start=1 with m_exc=1 same cycle -> req=1, stall=0, md_busy stays 0 next cycle.
- Mult running (cnt=3), reset=1 one cycle -> md_busy=0 after edge; new mult later gives 5 busy cycles.
- d_eret=1, m_mtc0_epc=1 -> stall=1; next cycle m_mtc0_epc=0, e_mtc0_epc=0 -> stall=0.
